// File: rtl/coin_io_peripheral.sv
// -----------------------------------------------------------------------------
// coin_io_peripheral
//
// Memory-mapped coin acceptor / dispenser peripheral.
//   * Coin inputs (nickel, dime, quarter) are edge-detected. Edges seen in the
//     same cycle are summed into one 6-bit value. A nonzero sum is pushed into
//     a small FIFO.
//   * A refund button edge sets a sticky refund flag.
//   * Reading COIN (0x0) returns the head entry plus status bits, pops the
//     head and clears the refund/overflow flags.
//   * Writing OUT (0x4) from idle starts a PULSE_CYCLES-long pulse on the
//     selected outputs: bit31 vend, bit2 quarter_out, bit1 dime_out,
//     bit0 nickel_out. Reading OUT returns the busy bit in bit 0.
//
// Optional build macro:
//   COIN_IO_SYNC_EN - when defined, nickel/dime/quarter/refund pass through a
//                     2-flop synchronizer before edge detection.
//
// Parameters:
//   FIFO_DEPTH   - coin FIFO entries (power of two, >= 2)
//   PULSE_CYCLES - cycles an OUT pulse is held high
//
// Ports:
//   clock, reset_n                     - clock, async active-low reset
//   nickel, dime, quarter, refund      - level inputs from the coin mechanism
//   mem_address, mem_read_en,
//   mem_write_en, mem_write_value      - CPU bus (single-cycle strobes)
//   mem_read_value                     - combinational read data
//   nickel_out, dime_out,
//   quarter_out, vend                  - registered dispense pulses
// -----------------------------------------------------------------------------
module coin_io_peripheral #(
    parameter int FIFO_DEPTH   = 4,
    parameter int PULSE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        nickel,
    input  logic        dime,
    input  logic        quarter,
    input  logic        refund,
    input  logic [31:0] mem_address,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_value,
    output logic [31:0] mem_read_value,
    output logic        nickel_out,
    output logic        dime_out,
    output logic        quarter_out,
    output logic        vend
);

    localparam logic [31:0] ADDR_COIN = 32'h0000_0000;
    localparam logic [31:0] ADDR_OUT  = 32'h0000_0004;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam int PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    // Number of clock edges after reset release before edge detection is
    // trusted: the previous-value register (and synchronizer, if present)
    // must have sampled the real input so a coin already present at reset
    // release is not mistaken for a new event.
`ifdef COIN_IO_SYNC_EN
    localparam logic [1:0] WARM_LAST = 2'd3;
`else
    localparam logic [1:0] WARM_LAST = 2'd1;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    // Coin values summed for the edges detected in one cycle (max 40).
    function automatic logic [5:0] coin_sum(input logic [2:0] e);
        logic [5:0] s;
        s = 6'd0;
        if (e[0]) s = s + 6'd5;
        if (e[1]) s = s + 6'd10;
        if (e[2]) s = s + 6'd25;
        return s;
    endfunction

    // ---------------------------------------------------------------- inputs
    logic [3:0] raw_s;     // {refund, quarter, dime, nickel}
    logic [3:0] cond_s;
    logic [3:0] prev_q;
    logic [1:0] warm_q;
    logic       armed_s;
    logic [3:0] edge_s;

    assign raw_s = {refund, quarter, dime, nickel};

`ifdef COIN_IO_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    // Two-flop synchronizer on every mechanism input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    assign cond_s = sync2_q;
`else
    assign cond_s = raw_s;
`endif

    assign armed_s = (warm_q == WARM_LAST);
    assign edge_s  = cond_s & ~prev_q & {4{armed_s}};

    // Edge history and post-reset warm-up counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 4'b0000;
            warm_q <= 2'd0;
        end else begin
            prev_q <= cond_s;
            if (!armed_s) begin
                warm_q <= warm_q + 2'd1;
            end else begin
                warm_q <= warm_q;
            end
        end
    end

    // ------------------------------------------------------------------ FIFO
    logic [5:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             refund_q, refund_d;
    logic             ovf_q, ovf_d;

    logic [5:0] sum_s;
    logic       push_s;
    logic       coin_rd_s;
    logic       empty_s;
    logic       full_s;
    logic       pop_s;
    logic       accept_s;
    logic       drop_s;

    assign sum_s     = coin_sum(edge_s[2:0]);
    assign push_s    = (sum_s != 6'd0);
    assign coin_rd_s = mem_read_en && (mem_address == ADDR_COIN);
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign full_s    = (count_q == FULL_CNT);
    assign pop_s     = coin_rd_s && !empty_s;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign accept_s  = push_s && (!full_s || pop_s);
    assign drop_s    = push_s && full_s && !pop_s;

    // FIFO pointer/count and status-flag next state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        refund_d = refund_q;
        ovf_d    = ovf_q;

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A refund edge coinciding with a COIN read keeps the flag set.
        if (edge_s[3]) begin
            refund_d = 1'b1;
        end else if (coin_rd_s) begin
            refund_d = 1'b0;
        end else begin
            refund_d = refund_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (coin_rd_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage, pointers and flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 6'd0;
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            refund_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_q[wr_ptr_q] <= sum_s;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            refund_q <= refund_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------ OUT pulser
    state_t          state_q, state_d;
    logic [PC_W-1:0] cnt_q, cnt_d;
    logic [3:0]      outs_q, outs_d;    // {vend, quarter, dime, nickel}
    logic            out_wr_s;
    logic [3:0]      load_bits_s;

    assign out_wr_s    = mem_write_en && (mem_address == ADDR_OUT);
    assign load_bits_s = {mem_write_value[31], mem_write_value[2:0]};

    // OUT state machine next state and output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        outs_d  = outs_q;
        case (state_q)
            ST_IDLE: begin
                if (out_wr_s && (load_bits_s != 4'b0000)) begin
                    state_d = ST_PULSE;
                    cnt_d   = {PC_W{1'b0}};
                    outs_d  = load_bits_s;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = {PC_W{1'b0}};
                    outs_d  = 4'b0000;
                end
            end
            ST_PULSE: begin
                // Writes are ignored here; the pulse always runs to completion.
                if (cnt_q == PC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = {PC_W{1'b0}};
                    outs_d  = 4'b0000;
                end else begin
                    state_d = ST_PULSE;
                    cnt_d   = cnt_q + PC_ONE;
                    outs_d  = outs_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {PC_W{1'b0}};
                outs_d  = 4'b0000;
            end
        endcase
    end

    // OUT state machine registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {PC_W{1'b0}};
            outs_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outs_q  <= outs_d;
        end
    end

    assign vend        = outs_q[3];
    assign quarter_out = outs_q[2];
    assign dime_out    = outs_q[1];
    assign nickel_out  = outs_q[0];

    // ------------------------------------------------------------- read path
    logic [5:0] head_s;

    assign head_s = empty_s ? 6'd0 : mem_q[rd_ptr_q];

    // Combinational register read mux.
    always_comb begin
        mem_read_value = 32'h0000_0000;
        if (mem_address == ADDR_COIN) begin
            mem_read_value = {refund_q, !empty_s, ovf_q, 23'd0, head_s};
        end else if (mem_address == ADDR_OUT) begin
            mem_read_value = {31'd0, (state_q == ST_PULSE)};
        end else begin
            mem_read_value = 32'h0000_0000;
        end
    end

    // Write-data bits with no function in the register map.
    logic unused_s;
    assign unused_s = ^mem_write_value[30:3];

endmodule

// File: tb/tb_coin_io_peripheral.sv
module tb_coin_io_peripheral;

    logic        clock;
    logic        reset_n;
    logic        nickel;
    logic        dime;
    logic        quarter;
    logic        refund;
    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_value;
    logic [31:0] mem_read_value;
    logic        nickel_out;
    logic        dime_out;
    logic        quarter_out;
    logic        vend;

    int checks;
    int failures;

    coin_io_peripheral #(
        .FIFO_DEPTH  (4),
        .PULSE_CYCLES(16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .nickel         (nickel),
        .dime           (dime),
        .quarter        (quarter),
        .refund         (refund),
        .mem_address    (mem_address),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_write_value(mem_write_value),
        .mem_read_value (mem_read_value),
        .nickel_out     (nickel_out),
        .dime_out       (dime_out),
        .quarter_out    (quarter_out),
        .vend           (vend)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        n;
        logic        d;
        logic        q;
        logic [31:0] exp_first;
        logic [31:0] exp_second;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, vend, quarter_out, dime_out, nickel_out};
    endfunction

    task automatic coin_pulse(input logic n, input logic d, input logic q);
        nickel  = n;
        dime    = d;
        quarter = q;
        cycle();
        nickel  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;
        cycle();
    endtask

    task automatic read_coin(input string name, input logic [31:0] exp);
        mem_address = 32'h0;
        mem_read_en = 1'b1;
        #1;
        check(name, mem_read_value, exp);
        cycle();
        mem_read_en = 1'b0;
    endtask

    task automatic read_out(input string name, input logic [31:0] exp);
        mem_address = 32'h4;
        #1;
        check(name, mem_read_value, exp);
    endtask

    task automatic write_out(input logic [31:0] val);
        mem_address     = 32'h4;
        mem_write_value = val;
        mem_write_en    = 1'b1;
        cycle();
        mem_write_en    = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        nickel          = 1'b0;
        dime            = 1'b0;
        quarter         = 1'b0;
        refund          = 1'b0;
        mem_address     = 32'h0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_write_value = 32'h0;

        //                n     d     q     first          second
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h4000_000A, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h4000_001E, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4000_0028, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h4000_0005, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h4000_0019, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};

        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("reset_outs", outs(), 32'h0);
        read_out("reset_out_reg", 32'h0);
        mem_address = 32'h0;
        #1;
        check("reset_coin_reg", mem_read_value, 32'h0);
        repeat (3) cycle();

        // Table-driven coin sums
        for (int i = 0; i < 6; i++) begin
            coin_pulse(vecs[i].n, vecs[i].d, vecs[i].q);
            read_coin($sformatf("vec%0d_first", i), vecs[i].exp_first);
            read_coin($sformatf("vec%0d_second", i), vecs[i].exp_second);
        end

        // Five quarters into a 4-deep FIFO: fifth lost, overflow on first read only
        for (int i = 0; i < 5; i++) coin_pulse(1'b0, 1'b0, 1'b1);
        read_coin("ovf_read0", 32'h6000_0019);
        read_coin("ovf_read1", 32'h4000_0019);
        read_coin("ovf_read2", 32'h4000_0019);
        read_coin("ovf_read3", 32'h4000_0019);
        read_coin("ovf_read4", 32'h0000_0000);

        // Full FIFO with push and pop in the same cycle
        coin_pulse(1'b1, 1'b0, 1'b0);
        coin_pulse(1'b0, 1'b1, 1'b0);
        coin_pulse(1'b0, 1'b0, 1'b1);
        coin_pulse(1'b1, 1'b0, 1'b0);
        quarter     = 1'b1;
        mem_address = 32'h0;
        mem_read_en = 1'b1;
        #1;
        check("fullpop_head", mem_read_value, 32'h4000_0005);
        cycle();
        quarter     = 1'b0;
        mem_read_en = 1'b0;
        cycle();
        read_coin("fullpop_e1", 32'h4000_000A);
        read_coin("fullpop_e2", 32'h4000_0019);
        read_coin("fullpop_e3", 32'h4000_0005);
        read_coin("fullpop_e4", 32'h4000_0019);
        read_coin("fullpop_empty", 32'h0000_0000);

        // Refund flag and set-wins against a simultaneous read
        refund = 1'b1;
        cycle();
        refund = 1'b0;
        cycle();
        read_coin("refund_set", 32'h8000_0000);
        read_coin("refund_clr", 32'h0000_0000);
        refund      = 1'b1;
        mem_address = 32'h0;
        mem_read_en = 1'b1;
        #1;
        check("refund_pre", mem_read_value, 32'h0000_0000);
        cycle();
        refund      = 1'b0;
        mem_read_en = 1'b0;
        cycle();
        read_coin("refund_setwins", 32'h8000_0000);
        read_coin("refund_clr2", 32'h0000_0000);

        // Unmapped address: read 0, no pop, writes ignored
        coin_pulse(1'b0, 1'b1, 1'b0);
        mem_address     = 32'h8;
        mem_write_value = 32'h8000_0007;
        mem_write_en    = 1'b1;
        mem_read_en     = 1'b1;
        #1;
        check("unmapped_read", mem_read_value, 32'h0);
        cycle();
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        check("unmapped_outs", outs(), 32'h0);
        read_coin("unmapped_nopop", 32'h4000_000A);

        // OUT pulse: vend + quarter for exactly 16 cycles, second write ignored
        write_out(32'h8000_0004);
        check("pulse_k0", outs(), 32'hC);
        read_out("busy_k0", 32'h1);
        for (int k = 1; k < 16; k++) begin
            if (k == 3) write_out(32'h0000_0003);
            else cycle();
            check($sformatf("pulse_k%0d", k), outs(), 32'hC);
        end
        read_out("busy_k15", 32'h1);
        cycle();
        check("pulse_end", outs(), 32'h0);
        read_out("busy_end", 32'h0);

        // Nickel + dime pulse boundary
        write_out(32'h0000_0003);
        check("nd_start", outs(), 32'h3);
        repeat (15) cycle();
        check("nd_last", outs(), 32'h3);
        cycle();
        check("nd_end", outs(), 32'h0);

        // Writes with no output bits never start a pulse
        write_out(32'h0000_0000);
        check("zero_outs", outs(), 32'h0);
        read_out("zero_busy", 32'h0);
        write_out(32'h7FFF_FFF8);
        check("nobits_outs", outs(), 32'h0);
        read_out("nobits_busy", 32'h0);

        // Refund pending, coin queued, reset mid-pulse
        refund = 1'b1;
        cycle();
        refund = 1'b0;
        coin_pulse(1'b0, 1'b1, 1'b0);
        write_out(32'h8000_0004);
        repeat (3) cycle();
        check("pre_reset_outs", outs(), 32'hC);
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) cycle();
        read_coin("post_reset_coin", 32'h0);
        read_out("post_reset_busy", 32'h0);

        // Coin already high at reset release is not an event
        reset_n = 1'b0;
        quarter = 1'b1;
        cycle();
        reset_n = 1'b1;
        repeat (3) cycle();
        quarter = 1'b0;
        repeat (2) cycle();
        read_coin("held_coin_no_event", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
